// File: rtl/ara_test_harness.sv
// ============================================================================
// Module      : ara_test_harness (with ara_mem_model, ara_system, ara_soc)
// Description : Test harness around a behavioural Ara SoC stand-in. The
//               harness registers the SoC exit word, holds it once the
//               end-of-computation flag rises, and measures the last
//               completed performance window (runtime and CVA6 stall counts).
//               The SoC stand-in replays a command script preloaded into RRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Row-indexed memory image; init_val is loaded hierarchically at time zero.
module ara_mem_model #(
  parameter int unsigned           ADDR_W = 64,
  parameter int unsigned           DATA_W = 128,
  parameter int unsigned           ROWS   = 1024,
  parameter logic [ADDR_W-1:0]     BASE   = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int unsigned OFFS  = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(ROWS);

  logic [DATA_W-1:0] init_val [ROWS];
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  row_idx;

  // Byte address to row index; addresses beyond the model alias modulo ROWS.
  always_comb begin
    offset  = addr_i - BASE;
    row_idx = IDX_W'(offset >> OFFS);
    rdata_o = init_val[row_idx];
  end
endmodule

// Script sequencer standing in for the CVA6/Ara system.
// Script row layout (RRAM): [0] window enable, [1] D$ stall, [2] I$ stall,
// [3] scoreboard full, [4] exit from byte, [5] exit from DRAM word,
// [15:8] exit byte, [63:32] DRAM byte address; all other bits reserved-zero.
module ara_system #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiRespDelay = 200,
  parameter int unsigned RRAMLatency  = 10,
  parameter int unsigned PC_W         = 10,
  parameter logic [AxiAddrWidth-1:0] RRAM_BASE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic [AxiAddrWidth-1:0] rram_addr_o,
  input  logic [AxiDataWidth-1:0] rram_rdata_i,
  output logic [AxiAddrWidth-1:0] dram_addr_o,
  input  logic [AxiDataWidth-1:0] dram_rdata_i,
  input  logic                    uart_pready_i,
  input  logic                    uart_pslverr_i,
  output logic [63:0]             exit_o,
  output logic [0:0]              hw_cnt_en_o,
  output logic                    dcache_stall_o,
  output logic                    icache_stall_o,
  output logic                    sb_full_o
);
  // Boot wait: RRAM latency plus the AXI response delay rounded to 1 ns cycles.
  localparam int unsigned BOOT_RAW    = RRAMLatency + AxiRespDelay / 1000;
  localparam int unsigned BOOT_CYCLES = (BOOT_RAW == 0) ? 1 : BOOT_RAW;
  localparam int unsigned OFFS        = $clog2(AxiDataWidth / 8);
  localparam logic [AxiDataWidth-1:0] USED_MASK =
    AxiDataWidth'(64'hFFFF_FFFF_0000_FF3F);

  typedef enum logic [0:0] {ST_BOOT, ST_RUN} state_e;

  state_e         state_q, state_d;
  logic [31:0]    boot_cnt_q, boot_cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [63:0]    exit_q, exit_d;
  logic           cmd_valid;
  logic           dram_hi_zero;
  logic           uart_ok;

  // Next-state, script decode and exit-word update.
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    exit_d       = exit_q;
    rram_addr_o  = RRAM_BASE + (AxiAddrWidth'(pc_q) << OFFS);
    dram_addr_o  = AxiAddrWidth'(rram_rdata_i[63:32]);
    dram_hi_zero = (dram_rdata_i >> 64) == '0;
    uart_ok      = uart_pready_i & ~uart_pslverr_i;
    cmd_valid    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 32'd1;
        if (boot_cnt_q == 32'(BOOT_CYCLES - 1)) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        pc_d      = pc_q + 1'b1;
        cmd_valid = (rram_rdata_i & ~USED_MASK) == '0;
      end
      default: state_d = ST_BOOT;
    endcase
    // Exit word is posted through the console, so it commits only on a clean APB reply.
    if (cmd_valid && uart_ok) begin
      if (rram_rdata_i[5] && dram_hi_zero) begin
        exit_d = dram_rdata_i[63:0];
      end else if (rram_rdata_i[4]) begin
        exit_d = {56'd0, rram_rdata_i[15:8]};
      end
    end
    exit_o         = exit_q;
    hw_cnt_en_o[0] = cmd_valid & rram_rdata_i[0];
    dcache_stall_o = cmd_valid & rram_rdata_i[1];
    icache_stall_o = cmd_valid & rram_rdata_i[2];
    sb_full_o      = cmd_valid & rram_rdata_i[3];
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= '0;
      exit_q     <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      exit_q     <= exit_d;
    end
  end
endmodule

// SoC stand-in: system plus DRAM and RRAM images.
module ara_soc #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned VLEN         = 4096,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiRespDelay = 200,
  parameter int unsigned RRAMLatency  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_pready_i,
  input  logic        uart_pslverr_i,
  output logic [63:0] exit_o,
  output logic [0:0]  hw_cnt_en_o,
  output logic        dcache_stall_o,
  output logic        icache_stall_o,
  output logic        sb_full_o
);
  // Image depth scales with the vector register file so scripts fit any config.
  localparam int unsigned MEM_ROWS = VLEN * NrLanes / 16;
  localparam int unsigned PC_W     = $clog2(MEM_ROWS);
  localparam logic [AxiAddrWidth-1:0] DRAM_BASE = AxiAddrWidth'(64'h8000_0000);
  localparam logic [AxiAddrWidth-1:0] RRAM_BASE = AxiAddrWidth'(64'h1000_0000);

  logic [AxiAddrWidth-1:0] rram_addr, dram_addr;
  logic [AxiDataWidth-1:0] rram_rdata, dram_rdata;

  ara_mem_model #(
    .ADDR_W(AxiAddrWidth), .DATA_W(AxiDataWidth), .ROWS(MEM_ROWS), .BASE(DRAM_BASE)
  ) i_dram (
    .addr_i (dram_addr),
    .rdata_o(dram_rdata)
  );

  ara_mem_model #(
    .ADDR_W(AxiAddrWidth), .DATA_W(AxiDataWidth), .ROWS(MEM_ROWS), .BASE(RRAM_BASE)
  ) i_rram (
    .addr_i (rram_addr),
    .rdata_o(rram_rdata)
  );

  ara_system #(
    .AxiAddrWidth(AxiAddrWidth), .AxiDataWidth(AxiDataWidth),
    .AxiRespDelay(AxiRespDelay), .RRAMLatency(RRAMLatency),
    .PC_W(PC_W), .RRAM_BASE(RRAM_BASE)
  ) i_system (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rram_addr_o   (rram_addr),
    .rram_rdata_i  (rram_rdata),
    .dram_addr_o   (dram_addr),
    .dram_rdata_i  (dram_rdata),
    .uart_pready_i (uart_pready_i),
    .uart_pslverr_i(uart_pslverr_i),
    .exit_o        (exit_o),
    .hw_cnt_en_o   (hw_cnt_en_o),
    .dcache_stall_o(dcache_stall_o),
    .icache_stall_o(icache_stall_o),
    .sb_full_o     (sb_full_o)
  );
endmodule

module ara_test_harness #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned VLEN         = 4096,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64 * NrLanes / 2,
  parameter int unsigned AxiRespDelay = 200,
  parameter int unsigned RRAMLatency  = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [63:0] exit_o
);
  logic [63:0] soc_exit;
  logic [0:0]  hw_cnt_en;
  logic        dcache_stall, icache_stall, sb_full;
  logic        en, en_rise, en_fall;

  logic [63:0] exit_q, exit_d;
  logic        en_q, en_d;
  logic [63:0] runtime_cnt_q, runtime_cnt_d;
  logic [63:0] dcache_cnt_q, dcache_cnt_d;
  logic [63:0] icache_cnt_q, icache_cnt_d;
  logic [63:0] sbfull_cnt_q, sbfull_cnt_d;
  logic [63:0] runtime_buf_q, runtime_buf_d;
  logic [63:0] dcache_stall_buf_q, dcache_stall_buf_d;
  logic [63:0] icache_stall_buf_q, icache_stall_buf_d;
  logic [63:0] sb_full_buf_q, sb_full_buf_d;

  // Console is always ready with no error; its output is not observed.
  ara_soc #(
    .NrLanes(NrLanes), .VLEN(VLEN), .AxiAddrWidth(AxiAddrWidth),
    .AxiDataWidth(AxiDataWidth), .AxiRespDelay(AxiRespDelay), .RRAMLatency(RRAMLatency)
  ) i_ara_soc (
    .clk_i         (clk_i),
    .rst_ni        (~rst_i),
    .uart_pready_i (1'b1),
    .uart_pslverr_i(1'b0),
    .exit_o        (soc_exit),
    .hw_cnt_en_o   (hw_cnt_en),
    .dcache_stall_o(dcache_stall),
    .icache_stall_o(icache_stall),
    .sb_full_o     (sb_full)
  );

  // Exit latch and measurement-window counters with fall-edge snapshot.
  always_comb begin
    en      = hw_cnt_en[0];
    en_rise = en & ~en_q;
    en_fall = ~en & en_q;
    en_d    = en;
    exit_d  = exit_q[0] ? exit_q : soc_exit;

    runtime_cnt_d = runtime_cnt_q;
    dcache_cnt_d  = dcache_cnt_q;
    icache_cnt_d  = icache_cnt_q;
    sbfull_cnt_d  = sbfull_cnt_q;
    // The rising cycle itself counts, so a one-cycle window reads 1.
    if (en_rise) begin
      runtime_cnt_d = 64'd1;
      dcache_cnt_d  = {63'd0, dcache_stall};
      icache_cnt_d  = {63'd0, icache_stall};
      sbfull_cnt_d  = {63'd0, sb_full};
    end else if (en) begin
      runtime_cnt_d = runtime_cnt_q + 64'd1;
      dcache_cnt_d  = dcache_cnt_q + {63'd0, dcache_stall};
      icache_cnt_d  = icache_cnt_q + {63'd0, icache_stall};
      sbfull_cnt_d  = sbfull_cnt_q + {63'd0, sb_full};
    end

    runtime_buf_d      = runtime_buf_q;
    dcache_stall_buf_d = dcache_stall_buf_q;
    icache_stall_buf_d = icache_stall_buf_q;
    sb_full_buf_d      = sb_full_buf_q;
    if (en_fall) begin
      runtime_buf_d      = runtime_cnt_q;
      dcache_stall_buf_d = dcache_cnt_q;
      icache_stall_buf_d = icache_cnt_q;
      sb_full_buf_d      = sbfull_cnt_q;
    end
  end

  // Harness state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_q             <= '0;
      en_q               <= 1'b0;
      runtime_cnt_q      <= '0;
      dcache_cnt_q       <= '0;
      icache_cnt_q       <= '0;
      sbfull_cnt_q       <= '0;
      runtime_buf_q      <= '0;
      dcache_stall_buf_q <= '0;
      icache_stall_buf_q <= '0;
      sb_full_buf_q      <= '0;
    end else begin
      exit_q             <= exit_d;
      en_q               <= en_d;
      runtime_cnt_q      <= runtime_cnt_d;
      dcache_cnt_q       <= dcache_cnt_d;
      icache_cnt_q       <= icache_cnt_d;
      sbfull_cnt_q       <= sbfull_cnt_d;
      runtime_buf_q      <= runtime_buf_d;
      dcache_stall_buf_q <= dcache_stall_buf_d;
      icache_stall_buf_q <= icache_stall_buf_d;
      sb_full_buf_q      <= sb_full_buf_d;
    end
  end

  assign exit_o = exit_q;
endmodule

`default_nettype wire

// File: tb/tb_ara_test_harness.sv
// ============================================================================
// Module      : tb_ara_test_harness
// Description : Directed bench for ara_test_harness. Scripts are preloaded in
//               RRAM (row 0 at 0x1000_0000); with default parameters the
//               sequencer fetches script row j during cycle 10+j after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ara_test_harness;
  localparam int ROWS = 1024;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] exit_o;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  ara_test_harness dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .exit_o(exit_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release: after edge n the counter reads n.
  always @(posedge clk) cyc <= rst_i ? 0 : cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] mk(input bit en, input bit dc, input bit ic,
                                      input bit sb, input bit ex, input bit dx,
                                      input logic [7:0] b, input logic [31:0] addr);
    mk = {64'd0, addr, 16'd0, b, 2'b00, dx, ex, sb, ic, dc, en};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < ROWS; i++) begin
      dut.i_ara_soc.i_rram.init_val[i] = '0;
      dut.i_ara_soc.i_dram.init_val[i] = '0;
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset();
    enter_reset();
    vectors++; if (exit_o !== 64'd0) begin miscompares++; $display("FAIL reset_exit: got %h expected 0", exit_o); end
    vectors++; if (dut.runtime_buf_q !== 64'd0) begin miscompares++; $display("FAIL reset_runtime_buf: got %0d expected 0", dut.runtime_buf_q); end
    vectors++; if (dut.dcache_stall_buf_q !== 64'd0) begin miscompares++; $display("FAIL reset_dcache_buf: got %0d expected 0", dut.dcache_stall_buf_q); end
    vectors++; if (dut.icache_stall_buf_q !== 64'd0) begin miscompares++; $display("FAIL reset_icache_buf: got %0d expected 0", dut.icache_stall_buf_q); end
    vectors++; if (dut.sb_full_buf_q !== 64'd0) begin miscompares++; $display("FAIL reset_sb_buf: got %0d expected 0", dut.sb_full_buf_q); end
    clear_mem();
    release_reset();
    wait_cyc(40);
    vectors++; if (exit_o !== 64'd0) begin miscompares++; $display("FAIL idle_exit: got %h expected 0", exit_o); end
  endtask

  task automatic test_pass();
    enter_reset();
    clear_mem();
    dut.i_ara_soc.i_rram.init_val[3] = mk(0, 0, 0, 0, 1, 0, 8'h01, 32'h0);
    dut.i_ara_soc.i_rram.init_val[6] = mk(0, 0, 0, 0, 1, 0, 8'h0F, 32'h0);
    release_reset();
    wait_cyc(14);
    vectors++; if (exit_o !== 64'd0) begin miscompares++; $display("FAIL pass_early: got %h expected 0", exit_o); end
    wait_cyc(15);
    vectors++; if (exit_o !== 64'd1) begin miscompares++; $display("FAIL pass_latency: got %h expected 1", exit_o); end
    wait_cyc(30);
    vectors++; if (exit_o !== 64'd1) begin miscompares++; $display("FAIL pass_hold: got %h expected 1", exit_o); end
  endtask

  task automatic test_fail_code();
    enter_reset();
    clear_mem();
    dut.i_ara_soc.i_rram.init_val[0] = mk(0, 0, 0, 0, 1, 0, 8'h0F, 32'h0);
    release_reset();
    wait_cyc(11);
    vectors++; if (exit_o !== 64'd0) begin miscompares++; $display("FAIL fail_early: got %h expected 0", exit_o); end
    wait_cyc(12);
    vectors++; if (exit_o !== 64'hF) begin miscompares++; $display("FAIL fail_word: got %h expected f", exit_o); end
    vectors++; if (exit_o[63:1] !== 63'd7) begin miscompares++; $display("FAIL fail_code: got %0d expected 7", exit_o[63:1]); end
  endtask

  task automatic test_window();
    enter_reset();
    clear_mem();
    for (int j = 0; j < 110; j++) begin
      dut.i_ara_soc.i_rram.init_val[j] = mk(j >= 2 && j <= 101,
                                            (j <= 31) || (j == 105),
                                            j >= 40 && j <= 49,
                                            j >= 90 && j <= 94, 0, 0, 8'h0, 32'h0);
    end
    release_reset();
    wait_cyc(112);
    vectors++; if (dut.runtime_buf_q !== 64'd0) begin miscompares++; $display("FAIL win_before_fall: got %0d expected 0", dut.runtime_buf_q); end
    wait_cyc(113);
    vectors++; if (dut.runtime_buf_q !== 64'd100) begin miscompares++; $display("FAIL win_runtime: got %0d expected 100", dut.runtime_buf_q); end
    vectors++; if (dut.dcache_stall_buf_q !== 64'd30) begin miscompares++; $display("FAIL win_dcache: got %0d expected 30", dut.dcache_stall_buf_q); end
    vectors++; if (dut.icache_stall_buf_q !== 64'd10) begin miscompares++; $display("FAIL win_icache: got %0d expected 10", dut.icache_stall_buf_q); end
    vectors++; if (dut.sb_full_buf_q !== 64'd5) begin miscompares++; $display("FAIL win_sbfull: got %0d expected 5", dut.sb_full_buf_q); end
    wait_cyc(200);
    vectors++; if (dut.runtime_buf_q !== 64'd100) begin miscompares++; $display("FAIL win_runtime_stable: got %0d expected 100", dut.runtime_buf_q); end
    vectors++; if (dut.dcache_stall_buf_q !== 64'd30) begin miscompares++; $display("FAIL win_dcache_stable: got %0d expected 30", dut.dcache_stall_buf_q); end
  endtask

  task automatic test_back_to_back();
    enter_reset();
    clear_mem();
    for (int j = 0; j < 80; j++) begin
      dut.i_ara_soc.i_rram.init_val[j] = mk((j <= 49) || (j >= 55 && j <= 74),
                                            j >= 60 && j <= 64, 0, j <= 9, 0, 0, 8'h0, 32'h0);
    end
    release_reset();
    wait_cyc(65);
    vectors++; if (dut.runtime_buf_q !== 64'd50) begin miscompares++; $display("FAIL b2b_first_runtime: got %0d expected 50", dut.runtime_buf_q); end
    vectors++; if (dut.sb_full_buf_q !== 64'd10) begin miscompares++; $display("FAIL b2b_first_sb: got %0d expected 10", dut.sb_full_buf_q); end
    vectors++; if (dut.dcache_stall_buf_q !== 64'd0) begin miscompares++; $display("FAIL b2b_first_dcache: got %0d expected 0", dut.dcache_stall_buf_q); end
    wait_cyc(90);
    vectors++; if (dut.runtime_buf_q !== 64'd20) begin miscompares++; $display("FAIL b2b_second_runtime: got %0d expected 20", dut.runtime_buf_q); end
    vectors++; if (dut.sb_full_buf_q !== 64'd0) begin miscompares++; $display("FAIL b2b_second_sb: got %0d expected 0", dut.sb_full_buf_q); end
    vectors++; if (dut.dcache_stall_buf_q !== 64'd5) begin miscompares++; $display("FAIL b2b_second_dcache: got %0d expected 5", dut.dcache_stall_buf_q); end
  endtask

  task automatic test_single_cycle();
    enter_reset();
    clear_mem();
    dut.i_ara_soc.i_rram.init_val[5] = mk(1, 1, 0, 0, 0, 0, 8'h0, 32'h0);
    release_reset();
    wait_cyc(20);
    vectors++; if (dut.runtime_buf_q !== 64'd1) begin miscompares++; $display("FAIL single_runtime: got %0d expected 1", dut.runtime_buf_q); end
    vectors++; if (dut.dcache_stall_buf_q !== 64'd1) begin miscompares++; $display("FAIL single_dcache: got %0d expected 1", dut.dcache_stall_buf_q); end
  endtask

  task automatic test_reset_midwindow();
    enter_reset();
    clear_mem();
    for (int j = 0; j < ROWS; j++) begin
      dut.i_ara_soc.i_rram.init_val[j] = mk((j <= 9) || (j >= 20), 1, 0, 0, 0, 0, 8'h0, 32'h0);
    end
    release_reset();
    wait_cyc(40);
    vectors++; if (dut.runtime_buf_q !== 64'd10) begin miscompares++; $display("FAIL mid_first_window: got %0d expected 10", dut.runtime_buf_q); end
    wait_cyc(60);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (dut.runtime_buf_q !== 64'd0) begin miscompares++; $display("FAIL mid_reset_buf: got %0d expected 0", dut.runtime_buf_q); end
    vectors++; if (dut.runtime_cnt_q !== 64'd0) begin miscompares++; $display("FAIL mid_reset_cnt: got %0d expected 0", dut.runtime_cnt_q); end
    for (int j = 0; j < ROWS; j++) begin
      dut.i_ara_soc.i_rram.init_val[j] = mk(1, 0, 0, 0, 0, 0, 8'h0, 32'h0);
    end
    release_reset();
    wait_cyc(200);
    vectors++; if (dut.runtime_buf_q !== 64'd0) begin miscompares++; $display("FAIL never_falls_buf: got %0d expected 0", dut.runtime_buf_q); end
    vectors++; if (dut.runtime_cnt_q !== 64'd190) begin miscompares++; $display("FAIL open_window_cnt: got %0d expected 190", dut.runtime_cnt_q); end
  endtask

  task automatic test_preload();
    enter_reset();
    clear_mem();
    // DRAM 0x8000_0040 with 16-byte rows is row 4; neighbours carry decoys.
    dut.i_ara_soc.i_dram.init_val[3] = 128'h45;
    dut.i_ara_soc.i_dram.init_val[4] = 128'h25;
    dut.i_ara_soc.i_dram.init_val[5] = 128'h33;
    dut.i_ara_soc.i_rram.init_val[0] = mk(0, 0, 0, 0, 0, 1, 8'h0, 32'h8000_0040);
    release_reset();
    wait_cyc(11);
    vectors++; if (exit_o !== 64'd0) begin miscompares++; $display("FAIL preload_early: got %h expected 0", exit_o); end
    wait_cyc(12);
    vectors++; if (exit_o !== 64'h25) begin miscompares++; $display("FAIL preload_dram_row4: got %h expected 25", exit_o); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_code();
    test_window();
    test_back_to_back();
    test_single_cycle();
    test_reset_midwindow();
    test_preload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
